// File: rtl/maxpool_relu.sv
// Max-pool + ReLU + shift/saturate over FILTER_SIZE flattened feature maps,
// producing one pooled element per cycle into a registered result bus.
module maxpool_relu #(
    parameter int FILTER_SIZE = 15,
    parameter int IN_BIT      = 26,
    parameter int IN_WIDTH    = 27,
    parameter int IN_HEIGHT   = 27,
    parameter int POOL        = 2,
    parameter int OUT_BIT     = 9,
    parameter int SHIFT       = 8,
    parameter int OUT_WIDTH   = IN_WIDTH / POOL,
    parameter int OUT_HEIGHT  = IN_HEIGHT / POOL
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                enable,
    input  logic [FILTER_SIZE*IN_BIT*IN_WIDTH*IN_HEIGHT-1:0]    filter_result,
    output logic [FILTER_SIZE*OUT_BIT*OUT_WIDTH*OUT_HEIGHT-1:0] pool_result,
    output logic                                                done
);

    // state  | meaning
    // IDLE   | waiting for enable; pool_result holds last pass
    // RUN    | one pooled element written per cycle in scan order
    // DONE   | pass complete; held while enable stays high

    localparam int OUT_TOT = FILTER_SIZE * OUT_BIT * OUT_WIDTH * OUT_HEIGHT;
    localparam int CW      = (OUT_WIDTH   > 1) ? $clog2(OUT_WIDTH)   : 1;
    localparam int RW      = (OUT_HEIGHT  > 1) ? $clog2(OUT_HEIGHT)  : 1;
    localparam int FW      = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam logic [IN_BIT-1:0] SAT_MAX = IN_BIT'((1 << (OUT_BIT - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [FW-1:0]       flt_q, flt_d;
    logic                done_q, done_d;
    logic [OUT_TOT-1:0]  pool_q;
    logic                last_elem;

    int                        f_i, r_i, c_i, in_idx, out_idx;
    logic signed [IN_BIT-1:0]  cand, win_max;
    logic [IN_BIT-1:0]         relu_v, shifted_v;
    logic [OUT_BIT-1:0]        pooled;

    assign last_elem = (col_q == CW'(OUT_WIDTH - 1)) &&
                       (row_q == RW'(OUT_HEIGHT - 1)) &&
                       (flt_q == FW'(FILTER_SIZE - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable)    state_d = S_RUN;
            S_RUN:   if (last_elem) state_d = S_DONE;
            S_DONE:  if (!enable)   state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    // Column fastest, then row, then filter; counters park at zero outside RUN.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        flt_d = flt_q;
        if (state_q == S_IDLE && enable) begin
            col_d = '0;
            row_d = '0;
            flt_d = '0;
        end else if (state_q == S_RUN) begin
            if (last_elem) begin
                col_d = '0;
                row_d = '0;
                flt_d = '0;
            end else if (col_q == CW'(OUT_WIDTH - 1)) begin
                col_d = '0;
                if (row_q == RW'(OUT_HEIGHT - 1)) begin
                    row_d = '0;
                    flt_d = flt_q + FW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        f_i     = int'(flt_q);
        r_i     = int'(row_q);
        c_i     = int'(col_q);
        in_idx  = ((f_i * IN_HEIGHT + r_i * POOL) * IN_WIDTH + c_i * POOL) * IN_BIT;
        win_max = filter_result[in_idx +: IN_BIT];
        cand    = win_max;
        for (int i = 0; i < POOL; i++) begin
            for (int j = 0; j < POOL; j++) begin
                in_idx = ((f_i * IN_HEIGHT + r_i * POOL + i) * IN_WIDTH + c_i * POOL + j) * IN_BIT;
                cand   = filter_result[in_idx +: IN_BIT];
                if (cand > win_max) win_max = cand;
            end
        end
        relu_v    = win_max[IN_BIT-1] ? '0 : win_max;
        shifted_v = relu_v >> SHIFT;
        pooled    = (shifted_v > SAT_MAX) ? SAT_MAX[OUT_BIT-1:0] : shifted_v[OUT_BIT-1:0];
        out_idx   = ((f_i * OUT_HEIGHT + r_i) * OUT_WIDTH + c_i) * OUT_BIT;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            flt_q   <= '0;
            done_q  <= 1'b0;
            pool_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            flt_q   <= flt_d;
            done_q  <= done_d;
            if (state_q == S_RUN) pool_q[out_idx +: OUT_BIT] <= pooled;
        end
    end

    assign pool_result = pool_q;
    assign done        = done_q;

endmodule

// File: tb/tb_maxpool_relu.sv
// Bench for maxpool_relu: three small instances (4x4 shift 0, 4x4 shift 2, 5x5 shift 0)
// checked cycle by cycle against a window-max reference plus literal expectations.
module tb_maxpool_relu;

    localparam int FS   = 2;
    localparam int IB   = 26;
    localparam int OB   = 9;
    localparam int INA  = FS * IB * 16;
    localparam int INC  = FS * IB * 25;
    localparam int OTOT = FS * OB * 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    int   sel = 0;
    logic chk_on = 1'b0;

    logic [INA-1:0]  fr_a, fr_b;
    logic [INC-1:0]  fr_c;
    logic [OTOT-1:0] pr_a, pr_b, pr_c, pr_sel;
    logic            done_a, done_b, done_c, done_sel;
    logic            en_a, en_b, en_c;

    int errors = 0;
    int checks = 0;
    int din [FS][5][5];

    always #5 clock = ~clock;

    assign en_a     = enable && (sel == 0);
    assign en_b     = enable && (sel == 1);
    assign en_c     = enable && (sel == 2);
    assign pr_sel   = (sel == 0) ? pr_a   : (sel == 1) ? pr_b   : pr_c;
    assign done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    maxpool_relu #(.FILTER_SIZE(FS), .IN_BIT(IB), .IN_WIDTH(4), .IN_HEIGHT(4), .POOL(2),
                   .OUT_BIT(OB), .SHIFT(0)) dut_a (
        .clock(clock), .reset(reset), .enable(en_a),
        .filter_result(fr_a), .pool_result(pr_a), .done(done_a));

    maxpool_relu #(.FILTER_SIZE(FS), .IN_BIT(IB), .IN_WIDTH(4), .IN_HEIGHT(4), .POOL(2),
                   .OUT_BIT(OB), .SHIFT(2)) dut_b (
        .clock(clock), .reset(reset), .enable(en_b),
        .filter_result(fr_b), .pool_result(pr_b), .done(done_b));

    maxpool_relu #(.FILTER_SIZE(FS), .IN_BIT(IB), .IN_WIDTH(5), .IN_HEIGHT(5), .POOL(2),
                   .OUT_BIT(OB), .SHIFT(0)) dut_c (
        .clock(clock), .reset(reset), .enable(en_c),
        .filter_result(fr_c), .pool_result(pr_c), .done(done_c));

    task automatic chk(input string name, input logic [OTOT-1:0] got, input logic [OTOT-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pack();
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    fr_c[(f*25 + r*5 + c)*IB +: IB] = IB'(din[f][r][c]);
                    if (r < 4 && c < 4) begin
                        fr_a[(f*16 + r*4 + c)*IB +: IB] = IB'(din[f][r][c]);
                        fr_b[(f*16 + r*4 + c)*IB +: IB] = IB'(din[f][r][c]);
                    end
                end
    endtask

    task automatic fill(input int v);
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) din[f][r][c] = v;
    endtask

    task automatic fill_random();
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) din[f][r][c] = int'($urandom_range(0, 3000)) - 1500;
    endtask

    // Output element k (scan order) = clamp(relu(max of its 2x2 window) >>> shift, 0..255).
    function automatic logic [OB-1:0] ref_elem(input int k, input int shift);
        int f, r, c, mx;
        f  = k / 4;
        r  = (k % 4) / 2;
        c  = k % 2;
        mx = din[f][2*r][2*c];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (din[f][2*r+i][2*c+j] > mx) mx = din[f][2*r+i][2*c+j];
        if (mx < 0) mx = 0;
        mx = mx >>> shift;
        if (mx > 255) mx = 255;
        return OB'(mx);
    endfunction

    // Reference: a start edge, then 8 write edges, then done until enable drops.
    int              m_phase = 0;
    int              m_k = 0;
    logic [OTOT-1:0] exp_pool = '0;
    logic            exp_done = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase  = 0;
            m_k      = 0;
            exp_pool = '0;
        end else begin
            if (m_phase == 0) begin
                if (enable) begin
                    m_phase = 1;
                    m_k     = 0;
                end
            end else if (m_phase == 1) begin
                exp_pool[m_k*OB +: OB] = ref_elem(m_k, (sel == 1) ? 2 : 0);
                if (m_k == 7) m_phase = 2;
                else          m_k++;
            end else if (!enable) begin
                m_phase = 0;
            end
        end
        exp_done = (m_phase == 2);
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("cyc_done", OTOT'(done_sel), OTOT'(exp_done));
            chk("cyc_pool", pr_sel, exp_pool);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset(input int s);
        tick();
        reset = 1'b0;
        enable = 1'b0;
        sel = s;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Returns negedges from enable rise until done seen; 1 start edge + 8 RUN edges = 9.
    task automatic run_pass(input bit hold, output int cycles);
        enable = 1'b1;
        tick();
        cycles = 1;
        if (!hold) enable = 1'b0;
        while (!done_sel && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc, cnt;
        logic [OTOT-1:0] lit;

        fill(0);
        pack();
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("reset_pool", pr_a, '0);
        chk("reset_done", OTOT'(done_a), '0);
        chk_on = 1'b1;

        // All ones, enable held high
        fill(1);
        pack();
        do_reset(0);
        run_pass(1'b1, cyc);
        chk("ones_cycles", OTOT'(cyc), OTOT'(9));
        for (int i = 0; i < 8; i++) lit[i*OB +: OB] = 9'd1;
        chk("ones_pool", pr_sel, lit);
        cnt = 0;
        repeat (4) begin
            tick();
            cnt += int'(done_sel);
        end
        chk("ones_done_held", OTOT'(cnt), OTOT'(4));
        enable = 1'b0;
        tick();
        chk("ones_done_drop", OTOT'(done_sel), '0);

        // ReLU: one positive window max, everything else negative
        fill(-2);
        din[0][0][0] = -5; din[0][0][1] = 3; din[0][1][0] = 7; din[0][1][1] = -1;
        pack();
        do_reset(0);
        run_pass(1'b1, cyc);
        chk("relu_pool", pr_sel, OTOT'(7));
        enable = 1'b0;
        tick();

        // Saturation with SHIFT=0
        fill(0);
        din[1][2][3] = 1000;
        pack();
        do_reset(0);
        run_pass(1'b1, cyc);
        chk("sat_pool", pr_sel, OTOT'(255) << 63);
        enable = 1'b0;
        tick();

        // SHIFT=2 instance
        fill(0);
        din[0][0][0] = 400;
        pack();
        do_reset(1);
        run_pass(1'b1, cyc);
        chk("shift_pool", pr_sel, OTOT'(100));
        enable = 1'b0;
        tick();

        // Reset mid-RUN, then a fresh pass
        fill(0);
        din[0][0][0] = 50; din[0][0][2] = 60; din[1][1][1] = 70;
        pack();
        do_reset(0);
        enable = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("midrst_pool", pr_sel, '0);
        chk("midrst_done", OTOT'(done_sel), '0);
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_pass(1'b1, cyc);
        chk("midrst_cycles", OTOT'(cyc), OTOT'(9));
        lit = '0;
        lit[0*OB +: OB] = 9'd50;
        lit[1*OB +: OB] = 9'd60;
        lit[4*OB +: OB] = 9'd70;
        chk("midrst_pool2", pr_sel, lit);
        enable = 1'b0;
        tick();

        // 5x5: trailing row/column must be ignored
        fill(1);
        for (int f = 0; f < FS; f++)
            for (int i = 0; i < 5; i++) begin
                din[f][4][i] = 500;
                din[f][i][4] = 500;
            end
        pack();
        do_reset(2);
        run_pass(1'b1, cyc);
        for (int i = 0; i < 8; i++) lit[i*OB +: OB] = 9'd1;
        chk("odd_pool", pr_sel, lit);
        enable = 1'b0;
        tick();

        // One-cycle enable pulse
        fill_random();
        pack();
        do_reset(0);
        run_pass(1'b0, cyc);
        chk("pulse_cycles", OTOT'(cyc), OTOT'(9));
        cnt = int'(done_sel);
        repeat (5) begin
            tick();
            cnt += int'(done_sel);
        end
        chk("pulse_done_len", OTOT'(cnt), OTOT'(1));

        // Random data, back-to-back passes without clearing
        for (int it = 0; it < 6; it++) begin
            fill_random();
            pack();
            do_reset(int'($urandom_range(0, 2)));
            for (int p = 0; p < 2; p++) begin
                run_pass(bit'($urandom_range(0, 1)), cyc);
                chk("rand_cycles", OTOT'(cyc), OTOT'(9));
                enable = 1'b0;
                repeat (2) tick();
                fill_random();
                pack();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
